// File: rtl/ntt_bitrev_reorder.sv
// Bit-reverse to natural-order reorder buffer for NTT output frames.
// Ports: clk/rst, in_* bit-reversed stream, out_* natural stream, frame_done.
module ntt_bitrev_reorder #(
  parameter int W = 32,
  parameter int N = 8,
  localparam int LOGN = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         frame_done
);

  localparam logic [LOGN-1:0] LAST = LOGN'(N-1);

  logic [W-1:0]    r_mem [2][N];
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [LOGN-1:0] r_wr_cnt;
  logic [LOGN-1:0] r_rd_cnt;
  logic            r_frame_done;

  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_wr_last;
  logic            w_rd_last;
  logic [LOGN-1:0] w_wr_addr;
  logic [1:0]      w_set;
  logic [1:0]      w_clr;

  function automatic logic [LOGN-1:0] bitrev(
    input logic [LOGN-1:0] a
  );
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

  assign in_ready   = !r_full[r_wr_bank];
  assign w_wr_en    = in_valid && in_ready;
  assign w_wr_last  = (r_wr_cnt == LAST);
  assign w_wr_addr  = bitrev(r_wr_cnt);

  assign out_valid  = r_full[r_rd_bank];
  assign w_rd_en    = out_valid && out_ready;
  assign w_rd_last  = (r_rd_cnt == LAST);
  assign out_data   = out_valid ? r_mem[r_rd_bank][r_rd_cnt] : '0;
  assign out_last   = out_valid && w_rd_last;
  assign frame_done = r_frame_done;

  // A closing write and a closing read always hit different banks,
  // so set and clear masks never overlap.
  assign w_set = (w_wr_en && w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr = (w_rd_en && w_rd_last) ? (2'b01 << r_rd_bank) : 2'b00;

  // Bank contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][w_wr_addr] <= in_data;
    end
  end

  // Counters are LOGN bits wide, so N-1 wraps to 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_full       <= (r_full | w_set) & ~w_clr;
      r_frame_done <= w_rd_en && w_rd_last;
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + LOGN'(1);
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + LOGN'(1);
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Testbench for ntt_bitrev_reorder: random and directed frames
// checked against a frame-level bit-reverse permutation model.
module tb_ntt_bitrev_reorder;

  localparam int W = 32;
  localparam int N = 8;
  localparam int LOGN = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         frame_done;

  int n_vec = 0;
  int n_err = 0;

  ntt_bitrev_reorder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Natural index j reads input position brev(j).
  function automatic int brev(input int j);
    int r = 0;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + ((j / (1 << b)) % 2);
    end
    return r;
  endfunction

  // Reference model: whole frames, permuted on completion.
  logic [W-1:0] q[$];
  logic [W-1:0] part[$];
  logic         exp_fd = 1'b0;
  logic         stall = 1'b0;
  logic [W-1:0] stall_d = '0;
  int           nfull;
  logic         m_out_ok;
  logic         m_in_ok;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      part.delete();
      exp_fd = 1'b0;
      stall = 1'b0;
    end else begin
      nfull = (q.size() + N - 1) / N;
      m_out_ok = (q.size() > 0);
      m_in_ok = (nfull < 2);
      chk("out_valid", W'(out_valid), W'(m_out_ok));
      chk("in_ready", W'(in_ready), W'(m_in_ok));
      chk("out_last", W'(out_last),
          W'(m_out_ok && (q.size() % N == 1)));
      chk("frame_done", W'(frame_done), W'(exp_fd));
      if (m_out_ok) chk("out_data", out_data, q[0]);
      else chk("out_idle", out_data, '0);
      if (stall) chk("stable", out_data, stall_d);
      stall = m_out_ok && !out_ready;
      stall_d = out_data;
      exp_fd = 1'b0;
      if (m_out_ok && out_ready) begin
        if (q.size() % N == 1) exp_fd = 1'b1;
        void'(q.pop_front());
      end
      if (in_valid && m_in_ok) begin
        part.push_back(in_data);
        if (part.size() == N) begin
          for (int j = 0; j < N; j++) q.push_back(part[brev(j)]);
          part.delete();
        end
      end
    end
  end

  // One cycle: drive at posedge+1, see the handshake at negedge.
  task automatic cyc(input logic v, input logic [W-1:0] d,
                     input logic r, output logic fire);
    in_valid = v;
    in_data = d;
    out_ready = r;
    @(negedge clk);
    fire = in_valid && in_ready && !rst;
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; pr = ready %.
  task automatic send(input logic [W-1:0] d, input int pr);
    logic f;
    int k = 0;
    do begin
      cyc(1'b1, d, ($urandom_range(99) < pr), f);
      k++;
    end while (!f && k < 300);
    if (!f) chk("send_timeout", W'(0), W'(1));
  endtask

  task automatic idle(input int n, input logic r);
    logic f;
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, r, f);
  endtask

  logic f;
  logic [W-1:0] d;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b1);

    // Single frame 10..17.
    for (int i = 0; i < N; i++) send(W'(10 + i), 100);
    idle(12, 1'b1);

    // Streaming: four back-to-back frames, also exercising the
    // simultaneous last-write / last-read boundary.
    for (int i = 0; i < 4 * N; i++) send(W'(i), 100);
    idle(12, 1'b1);

    // Backpressure: fill both banks, then hold a word.
    for (int i = 0; i < 2 * N; i++) send(W'(200 + i), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, W'(216), 1'b0, f);
      chk("held", W'(f), W'(0));
    end
    for (int i = 0; i < N; i++) send(W'(216 + i), 100);
    idle(2 * N + 4, 1'b1);

    // Random stalls over 20 frames.
    for (int i = 0; i < 20 * N; i++) begin
      d = $urandom;
      while ($urandom_range(3) == 0) begin
        cyc(1'b0, $urandom, ($urandom_range(2) != 0), f);
      end
      send(d, 66);
    end
    idle(3 * N, 1'b1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) send(W'(50 + i), 100);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1, f);
    rst = 1'b0;
    for (int i = 0; i < N; i++) send(W'(100 + i), 100);
    idle(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
